// File: rtl/rr_pkt_pkg.sv
// Shared types and defaults for the round-robin packet mux.
// Default sizes must agree with the arbiter the mux is paired with.
package rr_pkt_pkg;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BEATS = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pkt_mux_onehot2bin.sv
// One-hot to binary encoder; turns the locked port mask into a source index.
// An all-zero input yields index 0.
module onehot2bin #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] onehot,
    output logic [SRC_W-1:0]   bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                bin = bin | SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pkt_mux.sv
// Packet mux behind a round-robin arbiter: locks the granted port for a whole
// packet and streams its beats through one registered valid/ready stage.
module rr_pkt_mux
    import rr_pkt_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int SRC_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_last,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [NUM_REQ-1:0]        arb_req,
    input  logic [NUM_REQ-1:0]        arb_gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      trunc_err
);

    localparam int CNT_W = clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   lock_q;
    logic [NUM_REQ-1:0]   gnt_low;
    logic [CNT_W-1:0]     beat_cnt;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_last;
    logic                 force_last;
    logic                 beat_last;
    logic                 can_load;
    logic                 accept;
    logic [SRC_W-1:0]     src_idx;

    // A malformed grant is resolved to its lowest set bit.
    assign gnt_low    = arb_gnt & (~arb_gnt + NUM_REQ'(1));
    assign can_load   = ~out_valid | out_ready;
    assign force_last = (beat_cnt == LAST_CNT);
    assign beat_last  = sel_last | force_last;
    assign accept     = |(in_valid & in_ready);

    onehot2bin #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_src_enc (
        .onehot (lock_q),
        .bin    (src_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                assert ($onehot0(arb_gnt));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|arb_gnt)            state_d = XFER;
            XFER:    if (accept && beat_last) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Request is withheld during XFER so the arbiter rotates once per packet.
    always_comb begin
        arb_req  = '0;
        in_ready = '0;
        if (rst) begin
            if (state_q == IDLE) begin
                arb_req = in_valid;
            end else begin
                in_ready = lock_q & {NUM_REQ{can_load}};
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{lock_q[i]}});
            sel_last = sel_last | (in_last[i] & lock_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q   <= '0;
            beat_cnt <= '0;
        end else if (state_q == IDLE) begin
            if (|arb_gnt) begin
                lock_q   <= gnt_low;
                beat_cnt <= '0;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_last) begin
                lock_q <= '0;
            end
        end
    end

    // Output stage: loads on accept, otherwise drains when downstream takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= accept & force_last & ~sel_last;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= beat_last;
                out_src   <= src_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Bench for rr_pkt_mux with a behavioural round-robin arbiter, per-port beat
// sources and a scoreboard of expected output beats.
module tb_rr_pkt_mux;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 16;
    localparam int SRC_W     = 2;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [SRC_W-1:0]  s;
        logic              l;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ-1:0]        arb_req;
    logic [NUM_REQ-1:0]        arb_gnt;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      trunc_err;

    beat_t            src_q[NUM_REQ][$];
    exp_t             sb[$];
    logic [SRC_W-1:0] src_log[$];
    int               out_cyc_log[$];
    int               pcnt[NUM_REQ];
    logic [NUM_REQ-1:0] stall;
    logic [1:0]       rr_last;
    int               gnt_count;
    int               cyc;
    int               vld_rise_cyc;
    int               first_out_cyc;
    int               overlap_cnt;
    int               trunc_count;
    int               trunc_ok;
    int               checks = 0;
    int               passed = 0;
    int               fails  = 0;

    always #5 clk = ~clk;

    rr_pkt_mux #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .SRC_W     (SRC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .arb_req   (arb_req),
        .arb_gnt   (arb_gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .trunc_err (trunc_err)
    );

    // Round-robin arbiter: highest priority goes to the port after the last winner.
    always_comb begin
        logic found;
        int   idx;
        arb_gnt = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!found && arb_req[idx]) begin
                arb_gnt[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            rr_last <= 2'd3;
        end else if (|arb_gnt) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (arb_gnt[i]) rr_last <= 2'(i);
            end
            gnt_count++;
        end
    end

    // Sources: pop on handshake, build the expected beat, then present the next beat.
    always @(posedge clk) begin
        logic [NUM_REQ-1:0] fire;
        logic [NUM_REQ-1:0] prev;
        beat_t              b;
        logic               lst;
        fire = in_valid & in_ready;
        prev = in_valid;
        cyc++;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
                b   = src_q[i].pop_front();
                lst = b.l || (pcnt[i] == MAX_BEATS - 1);
                sb.push_back('{d: b.d, s: SRC_W'(i), l: lst});
                pcnt[i] = lst ? 0 : pcnt[i] + 1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                in_valid[i]                  = 1'b1;
                in_data[i*DATA_W +: DATA_W]  = src_q[i][0].d;
                in_last[i]                   = src_q[i][0].l;
            end else begin
                in_valid[i]                  = 1'b0;
                in_data[i*DATA_W +: DATA_W]  = '0;
                in_last[i]                   = 1'b0;
            end
        end
        if (prev == '0 && in_valid != '0 && vld_rise_cyc < 0) vld_rise_cyc = cyc;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if ((|arb_req) && (|in_ready)) overlap_cnt++;
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (trunc_err) begin
                trunc_count++;
                if (out_valid && out_last && out_data == 8'h1F && out_src == 2'd0) trunc_ok++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL out_beat_unexpected: got data=%h src=%0d last=%b, required no beat",
                             out_data, out_src, out_last);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_src, out_last} !== {e.d, e.s, e.l}) begin
                        fails++;
                        $display("FAIL out_beat: got data=%h src=%0d last=%b, required data=%h src=%0d last=%b",
                                 out_data, out_src, out_last, e.d, e.s, e.l);
                    end else begin
                        passed++;
                    end
                end
                src_log.push_back(out_src);
                out_cyc_log.push_back(cyc);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            pcnt[i] = 0;
        end
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic clear_logs();
        src_log.delete();
        out_cyc_log.delete();
        vld_rise_cyc  = -1;
        first_out_cyc = -1;
        overlap_cnt   = 0;
        trunc_count   = 0;
        trunc_ok      = 0;
    endtask

    task automatic push_pkt(input int p, input int n, input logic [DATA_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            src_q[p].push_back('{d: base + DATA_W'(k), l: (k == n - 1)});
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int  n;
        logic busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            busy = out_valid || (sb.size() != 0);
            for (int i = 0; i < NUM_REQ; i++) busy = busy || (src_q[i].size() != 0);
            if (busy) begin
                step(1);
                n++;
            end
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        src_q[0].push_back('{d: 8'h55, l: 1'b1});
        step(2);
        checks++;
        if ({out_valid, out_data, out_last, out_src, trunc_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d t=%b, required all zero",
                     out_valid, out_data, out_last, out_src, trunc_err);
        end else passed++;
        checks++;
        if (in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end else passed++;
        checks++;
        if (arb_req !== 4'b0000) begin
            fails++;
            $display("FAIL reset_arb_req: got %b with in_valid=%b, required 0000", arb_req, in_valid);
        end else passed++;
        do_reset();
    endtask

    task automatic test_single();
        clear_logs();
        out_ready = 1'b1;
        push_pkt(1, 3, 8'hA1);
        wait_drain("single", 40);
        checks++;
        if (first_out_cyc - vld_rise_cyc != 2) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, required 2", first_out_cyc - vld_rise_cyc);
        end else passed++;
        checks++;
        if (out_cyc_log.size() != 3 || out_cyc_log[2] - out_cyc_log[0] != 2) begin
            fails++;
            $display("FAIL single_back_to_back: got %0d beats, required 3 on consecutive cycles",
                     out_cyc_log.size());
        end else passed++;
    endtask

    task automatic test_round_robin();
        int g0;
        logic ok;
        do_reset();
        clear_logs();
        out_ready = 1'b1;
        g0 = gnt_count;
        push_pkt(1, 2, 8'h11);
        push_pkt(3, 2, 8'h31);
        wait_drain("rr", 60);
        ok = (src_log.size() == 4);
        if (ok) ok = (src_log[0] == 1 && src_log[1] == 1 && src_log[2] == 3 && src_log[3] == 3);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_order: got %0d beats in wrong order, required src 1,1,3,3", src_log.size());
        end else passed++;
        checks++;
        if (overlap_cnt != 0) begin
            fails++;
            $display("FAIL rr_req_during_xfer: got %0d cycles, required 0", overlap_cnt);
        end else passed++;
        checks++;
        if (gnt_count - g0 != 2) begin
            fails++;
            $display("FAIL rr_grant_count: got %0d, required 2", gnt_count - g0);
        end else passed++;
    endtask

    task automatic test_back_pressure();
        int n;
        logic [DATA_W-1:0] held;
        clear_logs();
        out_ready = 1'b1;
        push_pkt(2, 4, 8'hC0);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
        out_ready = 1'b0;
        held = out_data;
        step(1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_data !== held || in_ready[2] !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold: got d=%h v=%b rdy=%b, required d=%h v=1 rdy=0",
                         out_data, out_valid, in_ready[2], held);
            end else passed++;
            step(1);
        end
        out_ready = 1'b1;
        wait_drain("bp", 40);
        checks++;
        if (src_log.size() != 4) begin
            fails++;
            $display("FAIL bp_beat_count: got %0d, required 4", src_log.size());
        end else passed++;
    endtask

    task automatic test_truncation();
        int g0;
        clear_logs();
        out_ready = 1'b1;
        g0 = gnt_count;
        push_pkt(0, 18, 8'h10);
        wait_drain("trunc", 80);
        checks++;
        if (trunc_count != 1 || trunc_ok != 1) begin
            fails++;
            $display("FAIL trunc_pulse: got %0d pulses (%0d on beat 16), required 1 on beat 16",
                     trunc_count, trunc_ok);
        end else passed++;
        checks++;
        if (src_log.size() != 18 || gnt_count - g0 != 2) begin
            fails++;
            $display("FAIL trunc_split: got %0d beats %0d grants, required 18 beats 2 grants",
                     src_log.size(), gnt_count - g0);
        end else passed++;
    endtask

    task automatic test_stall();
        int n;
        int zeros;
        clear_logs();
        out_ready = 1'b1;
        push_pkt(2, 4, 8'hD0);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
        stall[2] = 1'b1;
        push_pkt(0, 2, 8'hE0);
        step(6);
        zeros = 0;
        foreach (src_log[i]) if (src_log[i] == 0) zeros++;
        checks++;
        if (zeros != 0 || in_valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL stall_no_other_port: got %0d port0 beats, required 0", zeros);
        end else passed++;
        stall[2] = 1'b0;
        wait_drain("stall", 60);
        checks++;
        if (src_log.size() != 6 || src_log[3] != 2 || src_log[4] != 0 || src_log[5] != 0) begin
            fails++;
            $display("FAIL stall_resume_order: got %0d beats, required 4 from port2 then 2 from port0",
                     src_log.size());
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        int g0;
        clear_logs();
        out_ready = 1'b1;
        push_pkt(1, 4, 8'hB0);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1);
            n++;
        end
        step(1);
        rst = 1'b0;
        step(1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || arb_req !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_idle: got v=%b rdy=%b req=%b, required 0/0000/0000",
                     out_valid, in_ready, arb_req);
        end else passed++;
        clear_model();
        step(1);
        rst = 1'b1;
        clear_logs();
        g0 = gnt_count;
        push_pkt(3, 1, 8'h77);
        step(1);
        checks++;
        if (arb_req !== 4'b1000) begin
            fails++;
            $display("FAIL midreset_rearb: got arb_req=%b, required 1000", arb_req);
        end else passed++;
        wait_drain("midreset", 40);
        checks++;
        if (src_log.size() != 1 || gnt_count - g0 != 1) begin
            fails++;
            $display("FAIL midreset_fresh_pkt: got %0d beats %0d grants, required 1 and 1",
                     src_log.size(), gnt_count - g0);
        end else passed++;
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
        stall     = '0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        gnt_count = 0;
        cyc       = 0;
        clear_logs();
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_truncation();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
